// File: rtl/dm_ctrl.sv
// dm_ctrl: multi-cycle data-memory responder with byte-lane stores and extended loads.
// Optional DM_ALIGN_CHECK_EN suppresses misaligned accesses and raises exc_adel/exc_ades.
module dm_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] A,
  input  logic [3:0]  byteen,
  input  logic [31:0] wd,
  input  logic [2:0]  DEmod,
  output logic        stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W+1:0] a_q;
  logic [31:0] wd_q, w, shifted, ext;
  logic [3:0] be_q;
  logic [2:0] mod_q;
  logic we_q, fin, mis_ld, mis_st;
  logic [7:0] b;
  logic [15:0] h;
  logic unused_hi;
  assign unused_hi = ^A[31:ADDR_W+2];
  assign w = mem[a_q[ADDR_W+1:2]];
  assign fin = state == BUSY && cnt == '0;
  assign stall = (state == IDLE && req) || state == BUSY;
  always_comb begin
    shifted = w >> {a_q[1:0], 3'b000};
    b = shifted[7:0];
    h = a_q[1] ? w[31:16] : w[15:0];
    ext = mod_q == 3'd1 ? {24'b0, b} :
          mod_q == 3'd2 ? {{24{b[7]}}, b} :
          mod_q == 3'd3 ? {16'b0, h} :
          mod_q == 3'd4 ? {{16{h[15]}}, h} : w;
  end
`ifdef DM_ALIGN_CHECK_EN
  always_comb begin
    mis_ld = ((mod_q == 3'd3 || mod_q == 3'd4) && a_q[0]) ||
             (!(mod_q inside {3'd1, 3'd2, 3'd3, 3'd4}) && a_q[1:0] != 2'b00);
    mis_st = (be_q == 4'b1111 && a_q[1:0] != 2'b00) ||
             ((be_q == 4'b0011 || be_q == 4'b1100) && a_q[0]);
  end
`else
  assign mis_ld = 1'b0;
  assign mis_st = 1'b0;
`endif
  // Reset clears the whole array, so an in-flight store can never commit across it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (fin && we_q && !mis_st) begin
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[a_q[ADDR_W+1:2]][8*i +: 8] <= wd_q[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      if (state == IDLE && req) begin
        a_q <= A[ADDR_W+1:0];
        we_q <= we;
        be_q <= byteen;
        wd_q <= wd;
        mod_q <= DEmod;
        cnt <= CW'(LATENCY - 1);
        state <= BUSY;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (fin) begin
        state <= DONE;
        rvalid <= 1'b1;
        if (!we_q && !mis_ld) rdata <= ext;
        exc_adel <= !we_q && mis_ld;
        exc_ades <= we_q && mis_st;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
